// File: rtl/button_event_detector_if.sv
// Button-side signal bundle: the debounced key level in, and the event strobes plus held level out.
interface button_event_detector_if;
    logic key_in;
    logic press_pulse;
    logic click_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic release_pulse;
    logic held;

    // master drives the key level and consumes events; slave is the detector
    modport master (
        output key_in,
        input  press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, held
    );

    modport slave (
        input  key_in,
        output press_pulse, click_pulse, long_pulse, repeat_pulse, release_pulse, held
    );
endinterface

// File: rtl/button_event_detector.sv
// Turns a debounced active-low key level into one-cycle press/click/long/repeat/release strobes.
// Optional auto-repeat in HELD is compiled in by defining AUTO_REPEAT_EN.
module button_event_detector #(
    parameter int TICK_CYCLES   = 50000,
    parameter int LONG_PRESS_MS = 1000,
    parameter int REPEAT_MS     = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    button_event_detector_if.slave   bus,
    output logic [1:0]               state_dbg
);

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        PRESSED  = 2'd2,
        HELD     = 2'd3
    } state_t;

    localparam int MS_MAX = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
    localparam int MW     = $clog2(MS_MAX + 1);
    localparam int TW     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [MW-1:0] MS_SAT    = MW'(MS_MAX);
    localparam logic [MW-1:0] LONG_LAST = MW'(LONG_PRESS_MS - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [MW-1:0] REP_LAST  = MW'(REPEAT_MS - 1);
`endif

    logic          key_q;
    state_t        state, state_nxt;
    logic [TW-1:0] tick_cnt, tick_nxt, tick_inc;
    logic [MW-1:0] ms_cnt, ms_nxt, ms_inc;
    logic          wrap;

    logic press_q, click_q, long_q, repeat_q, release_q, held_q;
    logic press_nxt, click_nxt, long_nxt, repeat_nxt, release_nxt, held_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q     <= 1'b0;
            state     <= WAIT_REL;
            tick_cnt  <= '0;
            ms_cnt    <= '0;
            press_q   <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            key_q     <= bus.key_in;
            state     <= state_nxt;
            tick_cnt  <= tick_nxt;
            ms_cnt    <= ms_nxt;
            press_q   <= press_nxt;
            click_q   <= click_nxt;
            long_q    <= long_nxt;
            repeat_q  <= repeat_nxt;
            release_q <= release_nxt;
            held_q    <= held_nxt;
        end
    end

    // Thresholds fire on the edge where ms_cnt would reach the target, so the strobe
    // lands exactly N*TICK_CYCLES cycles after the previous event.
    always_comb begin
        wrap     = (tick_cnt == TICK_LAST);
        tick_inc = wrap ? '0 : tick_cnt + TW'(1);
        ms_inc   = (wrap && (ms_cnt != MS_SAT)) ? ms_cnt + MW'(1) : ms_cnt;

        state_nxt   = state;
        tick_nxt    = '0;
        ms_nxt      = '0;
        press_nxt   = 1'b0;
        click_nxt   = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        release_nxt = 1'b0;

        case (state)
            WAIT_REL: begin
                if (key_q) state_nxt = IDLE;
            end
            IDLE: begin
                if (!key_q) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                end
            end
            PRESSED: begin
                // release is checked first so it wins over a coincident threshold
                if (key_q) begin
                    state_nxt   = IDLE;
                    click_nxt   = 1'b1;
                    release_nxt = 1'b1;
                end else if (wrap && (ms_cnt == LONG_LAST)) begin
                    state_nxt = HELD;
                    long_nxt  = 1'b1;
                end else begin
                    tick_nxt = tick_inc;
                    ms_nxt   = ms_inc;
                end
            end
            HELD: begin
                if (key_q) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
`ifdef AUTO_REPEAT_EN
                end else if (wrap && (ms_cnt == REP_LAST)) begin
                    repeat_nxt = 1'b1;
`endif
                end else begin
                    tick_nxt = tick_inc;
                    ms_nxt   = ms_inc;
                end
            end
            default: state_nxt = WAIT_REL;
        endcase

        held_nxt = (state_nxt == HELD);
    end

    assign bus.press_pulse   = press_q;
    assign bus.click_pulse   = click_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.release_pulse = release_q;
    assign bus.held          = held_q;
    assign state_dbg         = state;

endmodule

// File: tb/tb_button_event_detector.sv
// Bench for button_event_detector: table of per-cycle key/reset vectors with expected strobes,
// checked through an expected-value queue, plus a hand-written post-reset state sequence.
module tb_button_event_detector;

    localparam int TICK     = 4;
    localparam int LONG     = 3;
    localparam int REP      = 2;
    localparam int LONG_CYC = LONG * TICK;
    localparam int REP_CYC  = REP * TICK;
    localparam int NMAX     = 512;

    // expected-vector bit positions: {held, release, repeat, long, click, press}
    localparam int B_PRESS   = 0;
    localparam int B_CLICK   = 1;
    localparam int B_LONG    = 2;
    localparam int B_REPEAT  = 3;
    localparam int B_RELEASE = 4;
    localparam int B_HELD    = 5;

    typedef struct {
        logic       rst;
        logic       key;
        logic [5:0] exp;
    } vec_t;

    vec_t       vecs[NMAX];
    int         nv = 0;
    logic [5:0] exp_q[$];
    int         checks = 0;
    int         failures = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_dbg;
    logic [5:0] outs;
    logic [5:0] e;

    button_event_detector_if bus_if ();

    button_event_detector #(
        .TICK_CYCLES   (TICK),
        .LONG_PRESS_MS (LONG),
        .REPEAT_MS     (REP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    assign outs = {bus_if.held, bus_if.release_pulse, bus_if.repeat_pulse,
                   bus_if.long_pulse, bus_if.click_pulse, bus_if.press_pulse};

    task automatic check(input string name, input int idx, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @%0d got=%b exp=%b (held,rel,rep,long,click,press)", name, idx, got, exp);
        end
    endtask

    task automatic push_vec(input logic r, input logic k);
        if (nv < NMAX) begin
            vecs[nv].rst = r;
            vecs[nv].key = k;
            vecs[nv].exp = 6'd0;
            nv++;
        end
    endtask

    task automatic add_level(input logic r, input logic k, input int n);
        for (int i = 0; i < n; i++) push_vec(r, k);
    endtask

    // pre cycles released, low cycles pressed, then post cycles released (or reset held
    // with the key still pressed when rst_end is set). Expected strobes come from the
    // documented latencies: press 2 cycles after the fall, release 2 after the rise,
    // long LONG_CYC after press, repeats every REP_CYC after long.
    task automatic add_press(input int pre, input int low, input int post, input bit rst_end);
        int b, f, r, p, lp, lim;
        b = nv;
        add_level(1'b0, 1'b1, pre);
        add_level(1'b0, 1'b0, low);
        if (rst_end) add_level(1'b1, 1'b0, post);
        else         add_level(1'b0, 1'b1, post);
        f   = b + pre;
        r   = f + low;
        p   = f + 1;
        lp  = p + LONG_CYC;
        lim = rst_end ? r - 1 : r;
        vecs[p].exp[B_PRESS] = 1'b1;
        if (lp <= r) begin
            if (lp <= lim) vecs[lp].exp[B_LONG] = 1'b1;
            for (int k = lp; k <= lim; k++) vecs[k].exp[B_HELD] = 1'b1;
`ifdef AUTO_REPEAT_EN
            for (int k = lp + REP_CYC; k <= lim; k += REP_CYC) vecs[k].exp[B_REPEAT] = 1'b1;
`endif
            if (!rst_end) vecs[r + 1].exp[B_RELEASE] = 1'b1;
        end else if (!rst_end) begin
            vecs[r + 1].exp[B_RELEASE] = 1'b1;
            vecs[r + 1].exp[B_CLICK]   = 1'b1;
        end
    endtask

    initial begin
        bus_if.key_in = 1'b1;
        rst = 1'b1;

        add_level(1'b0, 1'b1, 20);          // post-reset idle
        add_press(2, 5, 4, 1'b0);           // short click
        add_press(2, 12, 4, 1'b0);          // release coincides with long threshold
        add_press(2, 13, 4, 1'b0);          // long, then immediate release
        add_press(2, 20, 4, 1'b0);          // release coincides with first repeat
        add_press(2, 40, 4, 1'b0);          // long press with repeats
        add_press(2, 20, 3, 1'b1);          // reset while held
        add_level(1'b0, 1'b0, 10);          // still pressed after reset: silent
        add_press(3, 5, 4, 1'b0);           // fresh press after release

        // reset and the two-cycle climb from WAIT_REL to IDLE
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", -1, outs, 6'd0);
        check("reset_state", -1, {4'd0, state_dbg}, 6'd0);
        rst = 1'b0;
        bus_if.key_in = 1'b1;
        @(posedge clk);
        #1;
        check("wait_rel_state", -1, {4'd0, state_dbg}, 6'd0);
        @(posedge clk);
        #1;
        check("idle_state", -1, {4'd0, state_dbg}, 6'd1);
        check("idle_outs", -1, outs, 6'd0);

        for (int i = 0; i < nv; i++) begin
            rst = vecs[i].rst;
            bus_if.key_in = vecs[i].key;
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty @%0d", i);
            end else begin
                e = exp_q.pop_front();
                check("vec", i, outs, e);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
